// File: rtl/mat_result_streamer.sv
// Captures an N x N result matrix in one cycle and drains it as a row-major
// valid/ready element stream, chaining frames without a bubble.
module mat_result_streamer #(
  parameter int unsigned N      = 3,
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned IDX_W  = $clog2(N*N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [N*N*ELEM_W-1:0]   result_flat,
  output logic                    load_ready,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ELEM_W-1:0]       m_data,
  output logic [IDX_W-1:0]        m_index,
  output logic                    m_last,
  output logic [7:0]              frame_cnt,
  output logic                    err_overrun
);

  localparam int unsigned NUM_ELEM = N*N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM-1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   buf_q [NUM_ELEM];
  logic [ELEM_W-1:0]   buf_d [NUM_ELEM];
  logic [IDX_W-1:0]    idx_q, idx_d, nxt_idx;
  logic                valid_q, valid_d;
  logic [ELEM_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [7:0]          frame_q, frame_d;
  logic                err_q, err_d;
  logic                beat, end_beat, accept;

  assign beat       = valid_q && m_ready;
  assign end_beat   = beat && last_q;
  assign load_ready = (state_q == IDLE) || end_beat;
  assign accept     = load && load_ready;
  assign nxt_idx    = idx_q + IDX_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    frame_d = frame_q;
    err_d   = err_q | (load & ~load_ready);

    if (end_beat) frame_d = frame_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (accept) state_d = STREAM;
      end
      STREAM: begin
        if (end_beat && !accept) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (beat && !end_beat) begin
          idx_d  = nxt_idx;
          data_d = buf_q[nxt_idx];
          last_d = (nxt_idx == LAST_IDX);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame can start from IDLE or on the final beat of the current one.
    if (accept) begin
      for (int i = 0; i < int'(NUM_ELEM); i++) begin
        buf_d[i] = result_flat[i*ELEM_W +: ELEM_W];
      end
      idx_d   = '0;
      data_d  = result_flat[ELEM_W-1:0];
      last_d  = (LAST_IDX == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < int'(NUM_ELEM); i++) buf_q[i] <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_index     = idx_q;
  assign m_last      = last_q;
  assign frame_cnt   = frame_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer: drain, backpressure, back-to-back,
// overrun, mid-frame reset and frame counter wrap.
module tb_mat_result_streamer;

  localparam int unsigned N  = 3;
  localparam int unsigned EW = 16;
  localparam int unsigned IW = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               load;
  logic [N*N*EW-1:0]  result_flat;
  logic               load_ready;
  logic               m_valid;
  logic               m_ready;
  logic [EW-1:0]      m_data;
  logic [IW-1:0]      m_index;
  logic               m_last;
  logic [7:0]         frame_cnt;
  logic               err_overrun;

  int checks = 0;
  int errors = 0;

  int ab_exp [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
  int id_exp [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int twos   [9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};

  mat_result_streamer #(.N(N), .ELEM_W(EW)) dut (
    .clk(clk), .reset(reset), .load(load), .result_flat(result_flat),
    .load_ready(load_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .frame_cnt(frame_cnt), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*N*EW-1:0] pack(input int v [9]);
    logic [N*N*EW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*EW +: EW] = EW'(v[i]);
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    load = 1'b0;
    m_ready = 1'b0;
    result_flat = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Checks one frame's element stream with m_ready held high.
  task automatic drain(input string tag, input int exp [9]);
    for (int i = 0; i < 9; i++) begin
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_index"}, 32'(m_index), 32'(i));
      chk({tag, "_data"},  32'(m_data),  32'(exp[i]));
      chk({tag, "_last"},  32'(m_last),  32'(i == 8));
      step();
    end
  endtask

  initial begin
    int e;
    logic [7:0] fc_mid;

    // Reset values
    do_reset();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_index", 32'(m_index), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);

    // Basic drain
    result_flat = pack(ab_exp);
    load = 1'b1;
    m_ready = 1'b1;
    step();
    load = 1'b0;
    result_flat = '0;
    drain("basic", ab_exp);
    chk("basic_valid_after", 32'(m_valid), 32'd0);
    chk("basic_last_after", 32'(m_last), 32'd0);
    chk("basic_fcnt", 32'(frame_cnt), 32'd1);

    // Backpressure: m_ready pattern 1,0,0 repeating
    result_flat = pack(ab_exp);
    load = 1'b1;
    step();
    load = 1'b0;
    result_flat = '0;
    e = 0;
    for (int c = 0; c < 40 && e < 9; c++) begin
      m_ready = (c % 3 == 0);
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_index", 32'(m_index), 32'(e));
      chk("bp_data", 32'(m_data), 32'(ab_exp[e]));
      chk("bp_last", 32'(m_last), 32'(e == 8));
      step();
      if (m_ready) e++;
    end
    chk("bp_all_beats", 32'(e), 32'd9);
    chk("bp_valid_after", 32'(m_valid), 32'd0);
    chk("bp_fcnt", 32'(frame_cnt), 32'd2);
    m_ready = 1'b1;

    // Back-to-back frames: identity loaded in the end_beat cycle
    do_reset();
    m_ready = 1'b1;
    result_flat = pack(ab_exp);
    load = 1'b1;
    step();
    load = 1'b0;
    result_flat = '0;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_first_data", 32'(m_data), 32'(ab_exp[i]));
      if (i == 8) begin
        result_flat = pack(id_exp);
        load = 1'b1;
        chk("b2b_load_ready", 32'(load_ready), 32'd1);
      end
      step();
    end
    load = 1'b0;
    result_flat = '0;
    chk("b2b_fcnt_mid", 32'(frame_cnt), 32'd1);
    drain("b2b_second", id_exp);
    chk("b2b_valid_after", 32'(m_valid), 32'd0);
    chk("b2b_fcnt", 32'(frame_cnt), 32'd2);

    // Overrun: load of all 2s rejected at index 4
    result_flat = pack(ab_exp);
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("ovr_index", 32'(m_index), 32'(i));
      chk("ovr_data", 32'(m_data), 32'(ab_exp[i]));
      if (i == 4) begin
        result_flat = pack(twos);
        load = 1'b1;
        chk("ovr_load_ready", 32'(load_ready), 32'd0);
        chk("ovr_err_before", 32'(err_overrun), 32'd0);
      end
      step();
      if (i == 4) begin
        load = 1'b0;
        chk("ovr_err_rise", 32'(err_overrun), 32'd1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("ovr_no_extra", 32'(m_valid), 32'd0);
      chk("ovr_err_sticky", 32'(err_overrun), 32'd1);
      step();
    end
    chk("ovr_fcnt", 32'(frame_cnt), 32'd3);

    // Reset mid-frame at index 5
    result_flat = pack(ab_exp);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    chk("mrst_index_pre", 32'(m_index), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_data", 32'(m_data), 32'd0);
    chk("mrst_index", 32'(m_index), 32'd0);
    chk("mrst_last", 32'(m_last), 32'd0);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mrst_err", 32'(err_overrun), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_no_beats", 32'(m_valid), 32'd0);
    end
    chk("mrst_fcnt_after", 32'(frame_cnt), 32'd0);

    // Counter wrap: 256 seamless frames
    result_flat = pack(id_exp);
    for (int c = 0; c < 1 + 9*255; c++) begin
      load = !m_valid || m_last;
      step();
    end
    load = 1'b0;
    fc_mid = frame_cnt;
    chk("wrap_fcnt_255", 32'(fc_mid), 32'd255);
    chk("wrap_seamless_valid", 32'(m_valid), 32'd1);
    chk("wrap_seamless_index", 32'(m_index), 32'd0);
    repeat (9) step();
    chk("wrap_fcnt_0", 32'(frame_cnt), 32'd0);
    chk("wrap_valid_after", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_result_streamer.md
# mat_result_streamer

Output-side companion to the 3x3 matrix multiplier. It captures a full N x N result matrix in one cycle and drains it as a row-major element stream over a valid/ready handshake, feeding a narrow downstream consumer such as a UART/DMA bridge or a checker. It is the reader of the multiplier's result array, in the same way the stimulus side is the writer of its operand arrays. Back-to-back frames stream without a bubble.

## Interface

Parameters:
- `N`, 3: matrix dimension; one frame holds N*N elements.
- `ELEM_W`, 16: element width, matching the multiplier result width.
- `IDX_W`, `$clog2(N*N)` (4 for N=3): width of the element index.

Ports:
- `clk`  in  1  the single clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  capture request for `result_flat`.
- `result_flat`  in  N*N*ELEM_W  packed result matrix; element [r][c] sits at bits `(r*N+c)*ELEM_W +: ELEM_W`.
- `load_ready`  out  1  combinational; a load is accepted in this cycle.
- `m_valid`  out  1  stream element valid.
- `m_ready`  in  1  consumer accepts the element.
- `m_data`  out  ELEM_W  current element.
- `m_index`  out  IDX_W  row-major index of `m_data`, from 0 to N*N-1.
- `m_last`  out  1  high with the element at index N*N-1.
- `frame_cnt`  out  8  number of completed frames; wraps from 255 to 0.
- `err_overrun`  out  1  sticky; set when a load is rejected.

## Operation

- FSM has two states, IDLE and STREAM. Reset enters IDLE.
- Definitions:
  - beat = `m_valid && m_ready`.
  - end_beat = beat && `m_last`.
  - `load_ready` = (state==IDLE) || end_beat.
  - accept = `load && load_ready`.
- On accept:
  - The whole `result_flat` is latched into an internal buffer.
  - The index is set to 0 and the FSM goes to STREAM.
  - The accept cycle alone defines the frame; later changes on `result_flat` have no effect.
- In STREAM:
  - `m_valid`=1.
  - `m_data` = buffer[index].
  - `m_last` = (index==N*N-1).
- On a beat that is not end_beat, index increments by 1.
- On end_beat:
  - `frame_cnt` increments by 1.
  - If accept happens in the same cycle, the index reloads to 0 and the FSM stays in STREAM with the new buffer contents, so there is no idle cycle.
  - Otherwise the FSM returns to IDLE, with `m_valid`=0 and `m_last`=0.
- Rejected load (`load && !load_ready`):
  - The input is ignored and the frame in progress is unaffected.
  - `err_overrun` goes high and stays high until reset.
- Stall rule: while `m_valid && !m_ready`, `m_data`, `m_index` and `m_last` hold their values.
- Widths: elements pass through unmodified, with no arithmetic on data. The index never exceeds N*N-1.
- Reset values: state=IDLE, `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, `frame_cnt`=0, `err_overrun`=0, buffer all zero.
- Reset asserted mid-frame aborts the frame immediately; no further beats are produced for it.

## Timing

- `m_valid`, `m_data`, `m_index`, `m_last`, `frame_cnt` and `err_overrun` are all registered.
- `load_ready` is the only combinational output; it depends on `m_ready`.
- Latency from an accept at edge k: element 0 is valid in the cycle after edge k.
- With `m_ready` held at 1, the N*N beats occur on N*N consecutive edges: k+1 through k+9 for N=3.
- `frame_cnt` updates on the edge of end_beat.
- Throughput: one element per cycle. Continuous frames run at a 100% duty cycle when `load` is presented during the end_beat cycle.
- `err_overrun` rises on the edge after the rejected load.

## Test plan

- **Basic drain.** After reset, load A*B with A=[1..9] and B=[9..1], `m_ready`=1.
  - Required: 9 beats on consecutive cycles: 30,24,18,84,69,54,138,114,90.
  - Required: indices 0-8, `m_last` only on 90, `frame_cnt`=1, then `m_valid`=0.
- **Backpressure.** Same frame, toggling `m_ready` in the pattern 1,0,0,1,…
  - Required: identical data order with no loss or duplication.
  - Required: `m_data` and `m_index` stable during every stall cycle.
- **Back-to-back frames.** Load the identity result [1,0,0,0,1,0,0,0,1] exactly in the end_beat cycle of the first frame.
  - Required: element 0 of the new frame appears in the next cycle with no gap.
  - Required: `frame_cnt`=2 after both frames.
- **Overrun.** Pulse `load` at index 4 with a result of all 2s.
  - Required: the current frame completes unchanged and `err_overrun`=1.
  - Required: no extra frame is streamed and `err_overrun` stays 1 until reset.
- **Reset mid-frame.** Assert `reset` (low) at index 5.
  - Required: all outputs return to their reset values asynchronously.
  - Required: no beats after release until a new load; `frame_cnt`=0.
- **Counter wrap.** Stream 256 frames.
  - Required: `frame_cnt` reads 255, then 0.
